// File: rtl/if_id_skid_register.sv
// IF/ID boundary: 2-entry skid buffer (output + skid register) with valid/ready handshake and flush.
// Optional IFID_PERF_COUNTERS_EN adds saturating bubble and flush counters.
module if_id_skid_register #(
    parameter int unsigned XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [XLEN-1:0] IF_PC,
    input  logic [XLEN-1:0] IF_PC_PLUS4,
    input  logic [31:0]     IF_INSTRUCTION,
    input  logic            IF_VALID,
    output logic            IF_READY,
    input  logic            ID_READY,
    input  logic            FLUSH,
    output logic            ID_VALID,
    output logic [XLEN-1:0] ID_PC,
    output logic [XLEN-1:0] ID_PC_PLUS4,
`ifdef IFID_PERF_COUNTERS_EN
    output logic [31:0]     ID_INSTRUCTION,
    output logic [31:0]     BUBBLE_COUNT,
    output logic [31:0]     FLUSH_COUNT
`else
    output logic [31:0]     ID_INSTRUCTION
`endif
);

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [XLEN-1:0] out_pc4_q, out_pc4_d;
    logic [31:0]     out_instr_q, out_instr_d;

    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
    logic [31:0]     skid_instr_q, skid_instr_d;

    logic            if_ready_q, if_ready_d;
    logic            accept;
    logic            consume;

    assign accept  = IF_VALID & if_ready_q;
    assign consume = out_valid_q & ID_READY;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;
        out_instr_d  = out_instr_q;
        skid_valid_d = skid_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        skid_instr_d = skid_instr_q;

        if (FLUSH) begin
            // Kill valid bits only; data registers keep their last contents.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (consume || !out_valid_q) begin
            if (skid_valid_q) begin
                // Skid is only occupied while IF_READY=0, so no accept can race this move.
                out_valid_d  = 1'b1;
                out_pc_d     = skid_pc_q;
                out_pc4_d    = skid_pc4_q;
                out_instr_d  = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_pc_d    = IF_PC;
                out_pc4_d   = IF_PC_PLUS4;
                out_instr_d = IF_INSTRUCTION;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_pc_d    = IF_PC;
            skid_pc4_d   = IF_PC_PLUS4;
            skid_instr_d = IF_INSTRUCTION;
        end

        if_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_pc4_q    <= '0;
            out_instr_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            skid_instr_q <= '0;
            if_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
            out_instr_q  <= out_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_instr_q <= skid_instr_d;
            if_ready_q   <= if_ready_d;
        end
    end

    assign IF_READY       = if_ready_q;
    assign ID_VALID       = out_valid_q;
    assign ID_PC          = out_pc_q;
    assign ID_PC_PLUS4    = out_pc4_q;
    assign ID_INSTRUCTION = out_valid_q ? out_instr_q : NOP_INSTR;

`ifdef IFID_PERF_COUNTERS_EN
    logic [31:0] bubble_count_q, bubble_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        bubble_count_d = bubble_count_q;
        flush_count_d  = flush_count_q;
        if (!out_valid_q && (bubble_count_q != 32'hFFFF_FFFF)) begin
            bubble_count_d = bubble_count_q + 32'd1;
        end
        if (FLUSH && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bubble_count_q <= '0;
            flush_count_q  <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign BUBBLE_COUNT = bubble_count_q;
    assign FLUSH_COUNT  = flush_count_q;
`else
`endif

endmodule

// File: tb/tb_if_id_skid_register.sv
// Scoreboard bench for if_id_skid_register: accepted fetches are queued and matched on consume.
// Build with IFID_PERF_COUNTERS_EN to also exercise the performance counters.
module tb_if_id_skid_register;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IF_PC, IF_PC_PLUS4, IF_INSTRUCTION;
    logic        IF_VALID, IF_READY, ID_READY, FLUSH, ID_VALID;
    logic [31:0] ID_PC, ID_PC_PLUS4, ID_INSTRUCTION;
`ifdef IFID_PERF_COUNTERS_EN
    logic [31:0] BUBBLE_COUNT, FLUSH_COUNT;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } entry_t;

    entry_t sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    if_id_skid_register #(
        .XLEN      (32),
        .NOP_INSTR (32'h00000013)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .IF_PC          (IF_PC),
        .IF_PC_PLUS4    (IF_PC_PLUS4),
        .IF_INSTRUCTION (IF_INSTRUCTION),
        .IF_VALID       (IF_VALID),
        .IF_READY       (IF_READY),
        .ID_READY       (ID_READY),
        .FLUSH          (FLUSH),
        .ID_VALID       (ID_VALID),
        .ID_PC          (ID_PC),
        .ID_PC_PLUS4    (ID_PC_PLUS4),
`ifdef IFID_PERF_COUNTERS_EN
        .ID_INSTRUCTION (ID_INSTRUCTION),
        .BUBBLE_COUNT   (BUBBLE_COUNT),
        .FLUSH_COUNT    (FLUSH_COUNT)
`else
        .ID_INSTRUCTION (ID_INSTRUCTION)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[19:0] ^ 20'h5A5A5, 12'h0B3};
    endfunction

    // Called at a negedge: scores the consume/accept the next posedge will perform, then drives it.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        entry_t e;
        if (ID_VALID && rdy && !fl) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_underflow: got ID_PC=%h with nothing outstanding", ID_PC);
            end else begin
                e = sb.pop_front();
                if ({ID_PC, ID_PC_PLUS4, ID_INSTRUCTION} !== {e.pc, e.pc4, e.instr})
                    $display("FAIL sb_order: got pc=%h pc4=%h ins=%h, want pc=%h pc4=%h ins=%h",
                             ID_PC, ID_PC_PLUS4, ID_INSTRUCTION, e.pc, e.pc4, e.instr);
                else n_pass++;
            end
        end
        if (fl) sb.delete();
        if (v && IF_READY && !fl) begin
            e.pc = pc; e.pc4 = pc + 32'd4; e.instr = instr_of(pc);
            sb.push_back(e);
        end
        IF_VALID = v; IF_PC = pc; IF_PC_PLUS4 = pc + 32'd4; IF_INSTRUCTION = instr_of(pc);
        ID_READY = rdy; FLUSH = fl;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic drain_and_check(input string name);
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        n_checks++;
        if (sb.size() != 0 || ID_VALID !== 1'b0)
            $display("FAIL %s_drain: left=%0d ID_VALID=%b, want left=0 ID_VALID=0",
                     name, sb.size(), ID_VALID);
        else n_pass++;
    endtask

    task automatic test_reset;
        IF_VALID = 0; IF_PC = 0; IF_PC_PLUS4 = 0; IF_INSTRUCTION = 0; ID_READY = 0; FLUSH = 0;
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        n_checks++;
        if ({IF_READY, ID_VALID, ID_INSTRUCTION, ID_PC, ID_PC_PLUS4} !== {1'b1, 1'b0, NOP, 64'h0})
            $display("FAIL reset_state: rdy=%b vld=%b ins=%h pc=%h pc4=%h, want 1 0 %h 0 0",
                     IF_READY, ID_VALID, ID_INSTRUCTION, ID_PC, ID_PC_PLUS4, NOP);
        else n_pass++;
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_streaming;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'(i * 4), 1'b1, 1'b0);
            n_checks++;
            if (ID_VALID !== 1'b1 || ID_PC !== 32'(i * 4) || IF_READY !== 1'b1)
                $display("FAIL stream_latency: vld=%b pc=%h rdy=%b, want 1 %h 1",
                         ID_VALID, ID_PC, IF_READY, 32'(i * 4));
            else n_pass++;
        end
        drain_and_check("stream");
    endtask

    task automatic test_stall;
        cycle(1'b1, 32'd0, 1'b0, 1'b0);
        cycle(1'b1, 32'd4, 1'b0, 1'b0);
        n_checks++;
        if (IF_READY !== 1'b0 || ID_PC !== 32'd0)
            $display("FAIL stall_full: rdy=%b pc=%h, want 0 0", IF_READY, ID_PC);
        else n_pass++;
        cycle(1'b1, 32'd8, 1'b0, 1'b0);
        n_checks++;
        if (IF_READY !== 1'b0 || ID_PC !== 32'd0 || ID_VALID !== 1'b1)
            $display("FAIL stall_hold: rdy=%b pc=%h vld=%b, want 0 0 1", IF_READY, ID_PC, ID_VALID);
        else n_pass++;
        cycle(1'b1, 32'd8, 1'b1, 1'b0);
        n_checks++;
        if (ID_PC !== 32'd4 || IF_READY !== 1'b1)
            $display("FAIL stall_release: pc=%h rdy=%b, want 4 1", ID_PC, IF_READY);
        else n_pass++;
        cycle(1'b1, 32'd8, 1'b1, 1'b0);
        drain_and_check("stall");
    endtask

    task automatic test_flush;
        cycle(1'b1, 32'd16, 1'b0, 1'b0);
        cycle(1'b1, 32'd20, 1'b0, 1'b0);
        cycle(1'b1, 32'd24, 1'b0, 1'b1);
        n_checks++;
        if (ID_VALID !== 1'b0 || ID_INSTRUCTION !== NOP || IF_READY !== 1'b1)
            $display("FAIL flush_kill: vld=%b ins=%h rdy=%b, want 0 %h 1",
                     ID_VALID, ID_INSTRUCTION, IF_READY, NOP);
        else n_pass++;
        n_checks++;
        if (ID_PC !== 32'd16)
            $display("FAIL flush_data_kept: pc=%h, want 00000010", ID_PC);
        else n_pass++;
        cycle(1'b1, 32'd100, 1'b1, 1'b0);
        n_checks++;
        if (ID_VALID !== 1'b1 || ID_PC !== 32'd100)
            $display("FAIL flush_refill: vld=%b pc=%h, want 1 00000064", ID_VALID, ID_PC);
        else n_pass++;
        drain_and_check("flush");
    endtask

    task automatic test_simultaneous;
        cycle(1'b1, 32'd4, 1'b0, 1'b0);
        cycle(1'b1, 32'd8, 1'b1, 1'b0);
        n_checks++;
        if (ID_VALID !== 1'b1 || ID_PC !== 32'd8 || IF_READY !== 1'b1)
            $display("FAIL simul_swap: vld=%b pc=%h rdy=%b, want 1 8 1", ID_VALID, ID_PC, IF_READY);
        else n_pass++;
        drain_and_check("simul");
    endtask

    task automatic test_back_to_back;
        logic [31:0] pc = 32'h0000_1000;
        logic        v;
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            // Offered PC only advances once the current one has been accepted.
            if (v && IF_READY) begin
                cycle(v, pc, 1'($urandom_range(0, 2) != 0), 1'b0);
                pc = pc + 32'd4;
            end else begin
                cycle(v, pc, 1'($urandom_range(0, 2) != 0), 1'b0);
            end
        end
        drain_and_check("b2b");
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 32'd40, 1'b0, 1'b0);
        cycle(1'b1, 32'd44, 1'b0, 1'b0);
        #2 RST = 1'b1;
        #1;
        n_checks++;
        if ({ID_VALID, IF_READY, ID_INSTRUCTION, ID_PC} !== {1'b0, 1'b1, NOP, 32'h0})
            $display("FAIL reset_mid: vld=%b rdy=%b ins=%h pc=%h, want 0 1 %h 0",
                     ID_VALID, IF_READY, ID_INSTRUCTION, ID_PC, NOP);
        else n_pass++;
        sb.delete();
        @(negedge CLK);
        RST = 1'b0;
        IF_VALID = 1'b0;
        @(negedge CLK);
    endtask

`ifdef IFID_PERF_COUNTERS_EN
    task automatic test_perf_counters;
        RST = 1'b1;
        IF_VALID = 1'b0; ID_READY = 1'b0; FLUSH = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (BUBBLE_COUNT !== 32'd3 || FLUSH_COUNT !== 32'd0)
            $display("FAIL perf_idle: bubble=%0d flush=%0d, want 3 0", BUBBLE_COUNT, FLUSH_COUNT);
        else n_pass++;
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++;
        if (BUBBLE_COUNT !== 32'd6 || FLUSH_COUNT !== 32'd2)
            $display("FAIL perf_flush: bubble=%0d flush=%0d, want 6 2", BUBBLE_COUNT, FLUSH_COUNT);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_streaming;
        test_stall;
        test_flush;
        test_simultaneous;
        test_back_to_back;
        test_reset_mid;
        test_streaming;
`ifdef IFID_PERF_COUNTERS_EN
        test_perf_counters;
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, want completion");
        $fatal(1);
    end

endmodule
